pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the 32-bit MIPS datapath. Holds the architectural PC and selects the next fetch address from sequential (PC+4), branch-target or jump-target sources. Runs a request/ready handshake with instruction memory and presents one fetched instruction at a time to decode, with stall and flush support. Its `pc_plus4[31:28]` feeds the jump-address bus, and that bus's 32-bit result returns here as `jump_target`.

---
 rtl/pc_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: next-PC selection, imem request/ready
// handshake, and single-entry presentation of fetched instructions to decode.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_redir_pend;
    logic [XLEN-1:0] r_redir_addr;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_instr_valid;
    logic            r_imem_req;
    logic            r_misalign;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic            w_redir_pend_nxt;
    logic [XLEN-1:0] w_redir_addr_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_misalign_nxt;

    logic            w_redir;
    logic [XLEN-1:0] w_raw_tgt;
    logic [XLEN-1:0] w_tgt;

    // Jump wins over branch; the target is forced to word alignment.
    assign w_redir   = jump | branch;
    assign w_raw_tgt = jump ? jump_target : branch_target;
    assign w_tgt     = {w_raw_tgt[XLEN-1:2], 2'b00};

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_addr_nxt = r_redir_addr;
        w_instr_nxt      = r_instr;
        w_pc_nxt         = r_pc;
        w_misalign_nxt   = r_misalign | (w_redir & (|w_raw_tgt[1:0]));

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (w_redir) begin
                    w_fetch_pc_nxt = w_tgt;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    if (w_redir) begin
                        w_fetch_pc_nxt   = w_tgt;
                        w_redir_pend_nxt = 1'b0;
                    end else if (r_redir_pend) begin
                        w_fetch_pc_nxt   = r_redir_addr;
                        w_redir_pend_nxt = 1'b0;
                    end else begin
                        w_instr_nxt    = imem_rdata;
                        w_pc_nxt       = r_fetch_pc;
                        w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
                        w_state_nxt    = S_VALID;
                    end
                end else if (w_redir) begin
                    // Address must stay put while the request is outstanding.
                    w_redir_pend_nxt = 1'b1;
                    w_redir_addr_nxt = w_tgt;
                end
            end
            S_VALID: begin
                if (w_redir) begin
                    w_fetch_pc_nxt = w_tgt;
                    w_state_nxt    = S_FETCH;
                end else if (!stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_redir_pend  <= 1'b0;
            r_redir_addr  <= '0;
            r_instr       <= '0;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_redir_pend  <= w_redir_pend_nxt;
            r_redir_addr  <= w_redir_addr_nxt;
            r_instr       <= w_instr_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_valid <= (w_state_nxt == S_VALID);
            r_imem_req    <= (w_state_nxt == S_FETCH);
            r_misalign    <= w_misalign_nxt;
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_fetch_pc;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign pc           = r_pc;
    assign pc_plus4     = r_pc + PC_STEP;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table, hand-written corner sequences,
// and a fetch scoreboard matching accepted requests to presented instructions.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch        (branch),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misalign_err  (misalign_err)
    );

    // Memory word differs from its address so pc/instr swaps are visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted, non-discarded requests are queued; each new presentation pops one.
    logic [31:0] sb_q[$];
    logic        tb_pend    = 1'b0;
    logic        prev_valid = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            sb_q.delete();
            tb_pend    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (instr_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: got presentation pc=%h expected none", pc);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check("sb_pc", pc, e);
                    check("sb_instr", instr, mem_word(e));
                end
            end
            if (imem_req) begin
                if (imem_ready) begin
                    if (!(jump || branch) && !tb_pend) sb_q.push_back(imem_addr);
                    tb_pend = 1'b0;
                end else if (jump || branch) begin
                    tb_pend = 1'b1;
                end
            end
            prev_valid = instr_valid;
        end
    end

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        branch;
        logic [31:0] bt;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic j, input logic [31:0] jt,
                                input logic b, input logic [31:0] bt, input logic rdy,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.jump = j; v.jt = jt; v.branch = b; v.bt = bt; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; jump = 1'b0; branch = 1'b0;
        jump_target = '0; branch_target = '0;
    endtask

    initial begin
        int cnt;
        //            stall jump jt            br  bt        rdy req addr          vld pc
        vecs[0]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'h0,          0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'h4,          0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h4);
        vecs[5]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'h8,          0, 32'h0);
        vecs[6]  = mk(1, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h8);
        vecs[7]  = mk(1, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h8);
        vecs[8]  = mk(1, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h8);
        vecs[9]  = mk(0, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h8);
        vecs[10] = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'hC,          0, 32'h0);
        vecs[11] = mk(0, 1, 32'h0040_0100,  1, 32'h200, 1, 0, 32'h0,          1, 32'hC);
        vecs[12] = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'h0040_0100,  0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,          0, 32'h0,   1, 0, 32'h0,          1, 32'h0040_0100);
        vecs[14] = mk(0, 0, 32'h0,          0, 32'h0,   1, 1, 32'h0040_0104,  0, 32'h0);

        clear_inputs();
        imem_ready = 1'b1;
        do_reset();

        // Reset state (the cycle right after the last reset edge is IDLE).
        check("rst_req",      32'(imem_req),     32'd0);
        check("rst_valid",    32'(instr_valid),  32'd0);
        check("rst_addr",     imem_addr,         32'h0);
        check("rst_pc",       pc,                32'h0);
        check("rst_pc_plus4", pc_plus4,          32'h4);
        check("rst_instr",    instr,             32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall; jump = vecs[i].jump; jump_target = vecs[i].jt;
            branch = vecs[i].branch; branch_target = vecs[i].bt; imem_ready = vecs[i].ready;
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
                check($sformatf("v%0d_instr", i), instr, mem_word(vecs[i].e_pc));
                check($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
            end
            @(negedge clk);
        end
        clear_inputs();

        // Branch while a request at 16 waits three cycles.
        do_reset();
        cnt = 0;
        while (!(imem_req && imem_addr == 32'd16) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_addr16: got timeout expected fetch at %h", 32'd16);
        end
        imem_ready = 1'b0; branch = 1'b1; branch_target = 32'h300;
        @(negedge clk);
        branch = 1'b0;
        check("wait2_req",   32'(imem_req),    32'd1);
        check("wait2_addr",  imem_addr,        32'd16);
        check("wait2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("wait3_addr",  imem_addr,        32'd16);
        imem_ready = 1'b1;
        @(negedge clk);
        check("discard_valid", 32'(instr_valid), 32'd0);
        check("redir_req",     32'(imem_req),    32'd1);
        check("redir_addr",    imem_addr,        32'h300);
        @(negedge clk);
        check("b300_valid", 32'(instr_valid), 32'd1);
        check("b300_pc",    pc,               32'h300);

        // Misaligned branch target, then wrap from the top of the address space.
        branch = 1'b1; branch_target = 32'h0000_0102;
        @(negedge clk);
        branch = 1'b0;
        check("mis_addr", imem_addr,         32'h100);
        check("mis_flag", 32'(misalign_err), 32'd1);
        @(negedge clk);
        check("mis_pc", pc, 32'h100);
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        @(negedge clk);
        jump = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("top_pc",       pc,       32'hFFFF_FFFC);
        check("top_pc_plus4", pc_plus4, 32'h0);
        @(negedge clk);
        check("wrap_addr",    imem_addr,         32'h0);
        check("wrap_req",     32'(imem_req),     32'd1);
        check("mis_sticky",   32'(misalign_err), 32'd1);

        // Reset in the middle of a wait.
        imem_ready = 1'b0;
        @(negedge clk);
        check("midwait_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_req",      32'(imem_req),     32'd0);
        check("mr_valid",    32'(instr_valid),  32'd0);
        check("mr_pc",       pc,                32'h0);
        check("mr_misalign", 32'(misalign_err), 32'd0);
        reset = 1'b0; imem_ready = 1'b1;
        check("mr_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("mr_restart_req",  32'(imem_req), 32'd1);
        check("mr_restart_addr", imem_addr,     32'h0);
        @(negedge clk);
        check("mr_first_pc", pc, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
